lsu: RTL and testbench
======================

Name: lsu

Overview:
Load/store unit that consumes the ALU result (`rd`) as the effective address for RISC-V RV32I loads and stores.
- Performs byte/halfword/word alignment checks, store lane steering and load sign/zero extension.
- Runs a valid/ready handshake to the data-memory port.
- Sits between the ALU and the writeback mux; the core stalls while `req_ready` is low.

Parameters:
XLEN, 32, data and address width; only 32 is supported.

Ports:
clk  input  1  clock, rising edge.
rst_n  input  1  reset, asynchronous, active-low.
req_valid  input  1  core presents a memory operation.
req_ready  output  1  LSU idle and accepting a request.
req_we  input  1  1 = store, 0 = load.
req_funct3  input  3  RISC-V width/sign field: 000 B, 001 H, 010 W, 100 BU, 101 HU.
req_addr  input  XLEN  effective address (ALU `rd`).
req_wdata  input  XLEN  store data (`rs2` value).
resp_valid  output  1  one-cycle completion pulse.
resp_rdata  output  XLEN  extended load data; 0 for stores and errors.
resp_err  output  1  misaligned, illegal funct3, or bus error; valid with `resp_valid`.
mem_valid  output  1  bus request.
mem_ready  input  1  bus accepts the request.
mem_we  output  1  bus write.
mem_addr  output  XLEN  word address, with bits [1:0] = 00.
mem_wstrb  output  4  byte enables.
mem_wdata  output  XLEN  lane-replicated store data.
mem_rvalid  input  1  bus response (read data or write ack).
mem_rdata  input  XLEN  bus read word.
mem_err  input  1  bus error; qualified by `mem_rvalid`.

Behaviour:
- State machine: IDLE, REQ, WAIT, RESP; state and all bus/resp outputs are registered.
- Reset (`rst_n` = 0, takes effect immediately):
  - State goes to IDLE.
  - `req_ready` = 1; `resp_valid`, `resp_err`, `resp_rdata`, `mem_valid`, `mem_we`, `mem_addr`, `mem_wstrb`, `mem_wdata` all 0.
  - Reset mid-transaction abandons the access.
- `req_ready` = 1 only in IDLE. `req_*` inputs are ignored in every other state.
- IDLE, on `req_valid` at the clock edge (cycle N), decode the request:
  - Illegal funct3: 011, 110, 111; also 100/101 when `req_we` = 1.
  - Misaligned: H/HU with `addr[0]` ≠ 0; W with `addr[1:0]` ≠ 00.
  - Illegal or misaligned → RESP with `resp_err` = 1 and `resp_rdata` = 0. No bus access; `resp_valid` is high in cycle N+1.
  - Otherwise latch `we`, `funct3`, `addr[1:0]`; drive `mem_addr` = {`addr[31:2]`, 00}, `mem_wstrb`, `mem_wdata`, `mem_we`; go to REQ.
- Store steering:
  - SB: `wstrb` = 0001 << `addr[1:0]`, `wdata` = 4 copies of `wdata[7:0]`.
  - SH: `wstrb` = 0011 << (2·`addr[1]`), `wdata` = 2 copies of `wdata[15:0]`.
  - SW: `wstrb` = 1111, `wdata` unchanged.
- Loads drive `mem_wstrb` = 0000 and `mem_wdata` = 0.
- REQ:
  - `mem_valid` = 1.
  - `mem_addr`, `mem_we`, `mem_wstrb`, `mem_wdata` are held stable until `mem_ready`.
  - On `mem_ready` → WAIT and `mem_valid` drops.
- WAIT:
  - `mem_rvalid` is sampled only in WAIT, so it is never accepted in the REQ cycle.
  - On `mem_rvalid` → RESP, with `resp_err` = `mem_err`.
  - Load data: `byte` = `rdata >> (8·addr[1:0])`, `half` = `rdata >> (16·addr[1])`.
  - Extension: B/H sign-extend, BU/HU zero-extend, W passes the word through.
  - Stores or `mem_err` = 1 give `resp_rdata` = 0.
- RESP: `resp_valid` = 1 for exactly one cycle, then → IDLE. `resp_rdata` and `resp_err` are held until the next response.
- Minimum latency:
  - Zero-wait bus (`mem_ready` in N+1, `mem_rvalid` in N+2): `resp_valid` in N+3.
  - Error path: `resp_valid` in N+1.
  - Back-to-back requests: the next accept is no earlier than the RESP→IDLE cycle.
- Spurious `mem_rvalid` in IDLE, REQ or RESP is ignored.
- No timeout; the LSU waits indefinitely in REQ or WAIT.

Test Plan:
1. LW `addr` 0x100, `mem_rdata` 0xDEADBEEF, zero-wait bus → `mem_addr` 0x100, `mem_wstrb` 0000, `resp_valid` at N+3 with `resp_rdata` 0xDEADBEEF, `resp_err` 0.
2. LB `addr` 0x103, `mem_rdata` 0x80112233 → `resp_rdata` 0xFFFFFF80; LBU same → 0x00000080; LH `addr` 0x102 → 0xFFFF8011.
3. SH `addr` 0x202, `wdata` 0x1234ABCD → `mem_addr` 0x200, `mem_we` 1, `wstrb` 1100, `mem_wdata` 0xABCDABCD; ack → `resp_rdata` 0, `resp_err` 0.
4. LW `addr` 0x101, and SB with funct3 100 → `resp_err` 1 at N+1, `mem_valid` never asserted, `req_ready` back to 1 at N+2.
5. `mem_ready` held low 5 cycles in REQ → `mem_valid` and all `mem_*` fields stable, `req_ready` 0; then `mem_rvalid` with `mem_err` 1 → `resp_err` 1, `resp_rdata` 0.
6. Assert `rst_n` low while in WAIT → `mem_valid`/`resp_valid` 0 immediately, `req_ready` 1; a stray `mem_rvalid` after release produces no `resp_valid`.

Source files
------------

// File: rtl/lsu.sv
// RV32I load/store unit: decodes width/alignment, steers store lanes, extends
// load data, and runs a single-outstanding valid/ready access to data memory.
module lsu #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_we,
  input  logic [2:0]      req_funct3,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  output logic            resp_valid,
  output logic [XLEN-1:0] resp_rdata,
  output logic            resp_err,
  output logic            mem_valid,
  input  logic            mem_ready,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [3:0]      mem_wstrb,
  output logic [XLEN-1:0] mem_wdata,
  input  logic            mem_rvalid,
  input  logic [XLEN-1:0] mem_rdata,
  input  logic            mem_err
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_e;

  state_e state_q, state_d;

  logic            we_q, we_d;
  logic [2:0]      f3_q, f3_d;
  logic [1:0]      off_q, off_d;
  logic            mem_valid_q, mem_valid_d;
  logic            mem_we_q, mem_we_d;
  logic [XLEN-1:0] mem_addr_q, mem_addr_d;
  logic [3:0]      mem_wstrb_q, mem_wstrb_d;
  logic [XLEN-1:0] mem_wdata_q, mem_wdata_d;
  logic            resp_valid_q, resp_valid_d;
  logic            resp_err_q, resp_err_d;
  logic [XLEN-1:0] resp_rdata_q, resp_rdata_d;

  logic            req_illegal;
  logic            req_misaligned;
  logic            req_bad;
  logic [3:0]      st_wstrb;
  logic [XLEN-1:0] st_wdata;
  logic [XLEN-1:0] ld_byte_word;
  logic [XLEN-1:0] ld_half_word;
  logic [XLEN-1:0] ld_data;

  // Request decode: only B/H/W/BU/HU exist, and unsigned widths are load-only.
  always_comb begin
    req_illegal = 1'b0;
    case (req_funct3)
      3'b011, 3'b110, 3'b111: req_illegal = 1'b1;
      3'b100, 3'b101:         req_illegal = req_we;
      default:                req_illegal = 1'b0;
    endcase
  end

  always_comb begin
    req_misaligned = 1'b0;
    case (req_funct3[1:0])
      2'b01:   req_misaligned = req_addr[0];
      2'b10:   req_misaligned = (req_addr[1:0] != 2'b00);
      default: req_misaligned = 1'b0;
    endcase
  end

  assign req_bad = req_illegal | req_misaligned;

  always_comb begin
    st_wstrb = 4'b0000;
    st_wdata = '0;
    if (req_we) begin
      case (req_funct3[1:0])
        2'b00: begin
          st_wstrb = 4'b0001 << req_addr[1:0];
          st_wdata = {4{req_wdata[7:0]}};
        end
        2'b01: begin
          st_wstrb = req_addr[1] ? 4'b1100 : 4'b0011;
          st_wdata = {2{req_wdata[15:0]}};
        end
        default: begin
          st_wstrb = 4'b1111;
          st_wdata = req_wdata;
        end
      endcase
    end
  end

  // Load lane extraction uses the byte offset latched at request time.
  assign ld_byte_word = mem_rdata >> {off_q, 3'b000};
  assign ld_half_word = mem_rdata >> {off_q[1], 4'b0000};

  always_comb begin
    ld_data = mem_rdata;
    case (f3_q)
      3'b000:  ld_data = {{24{ld_byte_word[7]}}, ld_byte_word[7:0]};
      3'b001:  ld_data = {{16{ld_half_word[15]}}, ld_half_word[15:0]};
      3'b100:  ld_data = {24'd0, ld_byte_word[7:0]};
      3'b101:  ld_data = {16'd0, ld_half_word[15:0]};
      default: ld_data = mem_rdata;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (req_valid) state_d = req_bad ? RESP : REQ;
      REQ:  if (mem_ready) state_d = WAIT;
      WAIT: if (mem_rvalid) state_d = RESP;
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output/next-value logic; every bus and response output comes from a register.
  always_comb begin
    we_d         = we_q;
    f3_d         = f3_q;
    off_d        = off_q;
    mem_valid_d  = mem_valid_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wstrb_d  = mem_wstrb_q;
    mem_wdata_d  = mem_wdata_q;
    resp_valid_d = 1'b0;
    resp_err_d   = resp_err_q;
    resp_rdata_d = resp_rdata_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (req_bad) begin
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
            resp_rdata_d = '0;
          end else begin
            we_d        = req_we;
            f3_d        = req_funct3;
            off_d       = req_addr[1:0];
            mem_valid_d = 1'b1;
            mem_we_d    = req_we;
            mem_addr_d  = {req_addr[XLEN-1:2], 2'b00};
            mem_wstrb_d = st_wstrb;
            mem_wdata_d = st_wdata;
          end
        end
      end
      REQ: begin
        if (mem_ready) mem_valid_d = 1'b0;
      end
      WAIT: begin
        if (mem_rvalid) begin
          resp_valid_d = 1'b1;
          resp_err_d   = mem_err;
          resp_rdata_d = (we_q || mem_err) ? '0 : ld_data;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q         <= 1'b0;
      f3_q         <= 3'b000;
      off_q        <= 2'b00;
      mem_valid_q  <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wstrb_q  <= 4'b0000;
      mem_wdata_q  <= '0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
    end else begin
      we_q         <= we_d;
      f3_q         <= f3_d;
      off_q        <= off_d;
      mem_valid_q  <= mem_valid_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wstrb_q  <= mem_wstrb_d;
      mem_wdata_q  <= mem_wdata_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_rdata_q <= resp_rdata_d;
    end
  end

  assign req_ready  = (state_q == IDLE);
  assign mem_valid  = mem_valid_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wstrb  = mem_wstrb_q;
  assign mem_wdata  = mem_wdata_q;
  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_err_q;
  assign resp_rdata = resp_rdata_q;

endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu: a vector table of zero-wait accesses plus
// hand-written stall, bus-error and reset-in-WAIT sequences.
module tb_lsu;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_valid;
  logic        mem_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        mem_err;

  int n_checks = 0;
  int n_fail   = 0;

  lsu #(.XLEN(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_valid  (mem_valid),
    .mem_ready  (mem_ready),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wstrb  (mem_wstrb),
    .mem_wdata  (mem_wdata),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata),
    .mem_err    (mem_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        merr;
    logic        exp_bad;
    logic [31:0] exp_maddr;
    logic [3:0]  exp_strb;
    logic [31:0] exp_mwdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  localparam int NV = 15;
  vec_t vecs [NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic run_vec(input int i);
    vec_t v;
    v = vecs[i];
    req_valid  = 1'b1;
    req_we     = v.we;
    req_funct3 = v.f3;
    req_addr   = v.addr;
    req_wdata  = v.wdata;
    tick();
    req_valid = 1'b0;
    if (v.exp_bad) begin
      check("err_resp_valid", {31'd0, resp_valid}, 32'd1);
      check("err_resp_err", {31'd0, resp_err}, 32'd1);
      check("err_resp_rdata", resp_rdata, 32'd0);
      check("err_mem_valid_n1", {31'd0, mem_valid}, 32'd0);
      check("err_req_ready_n1", {31'd0, req_ready}, 32'd0);
      tick();
      check("err_mem_valid_n2", {31'd0, mem_valid}, 32'd0);
      check("err_resp_valid_n2", {31'd0, resp_valid}, 32'd0);
      check("err_req_ready_n2", {31'd0, req_ready}, 32'd1);
    end else begin
      check("mem_valid", {31'd0, mem_valid}, 32'd1);
      check("req_ready_busy", {31'd0, req_ready}, 32'd0);
      check("mem_addr", mem_addr, v.exp_maddr);
      check("mem_wstrb", {28'd0, mem_wstrb}, {28'd0, v.exp_strb});
      check("mem_wdata", mem_wdata, v.exp_mwdata);
      check("mem_we", {31'd0, mem_we}, {31'd0, v.we});
      mem_ready = 1'b1;
      tick();
      mem_ready = 1'b0;
      check("mem_valid_drop", {31'd0, mem_valid}, 32'd0);
      check("resp_valid_early", {31'd0, resp_valid}, 32'd0);
      mem_rvalid = 1'b1;
      mem_rdata  = v.rdata;
      mem_err    = v.merr;
      tick();
      mem_rvalid = 1'b0;
      mem_err    = 1'b0;
      check("resp_valid", {31'd0, resp_valid}, 32'd1);
      check("resp_rdata", resp_rdata, v.exp_rdata);
      check("resp_err", {31'd0, resp_err}, {31'd0, v.exp_err});
      tick();
      check("resp_valid_pulse", {31'd0, resp_valid}, 32'd0);
      check("req_ready_back", {31'd0, req_ready}, 32'd1);
      check("resp_rdata_held", resp_rdata, v.exp_rdata);
    end
    $display("txn %0d we=%0d f3=%0d addr=%h -> rdata=%h err=%0d (failures so far %0d)",
             i, v.we, v.f3, v.addr, resp_rdata, resp_err, n_fail);
  endtask

  initial begin
    //               we    f3      addr          wdata         rdata         merr  bad   maddr         strb     mwdata        rdata         err
    vecs[0]  = '{1'b0, 3'b010, 32'h0000_0100, 32'h0,        32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0000_0100, 4'b0000, 32'h0,        32'hDEAD_BEEF, 1'b0};
    vecs[1]  = '{1'b0, 3'b000, 32'h0000_0103, 32'h0,        32'h8011_2233, 1'b0, 1'b0, 32'h0000_0100, 4'b0000, 32'h0,        32'hFFFF_FF80, 1'b0};
    vecs[2]  = '{1'b0, 3'b100, 32'h0000_0103, 32'h0,        32'h8011_2233, 1'b0, 1'b0, 32'h0000_0100, 4'b0000, 32'h0,        32'h0000_0080, 1'b0};
    vecs[3]  = '{1'b0, 3'b001, 32'h0000_0102, 32'h0,        32'h8011_2233, 1'b0, 1'b0, 32'h0000_0100, 4'b0000, 32'h0,        32'hFFFF_8011, 1'b0};
    vecs[4]  = '{1'b0, 3'b101, 32'h0000_0100, 32'h0,        32'h8011_A233, 1'b0, 1'b0, 32'h0000_0100, 4'b0000, 32'h0,        32'h0000_A233, 1'b0};
    vecs[5]  = '{1'b0, 3'b000, 32'h0000_0101, 32'h0,        32'h8011_2233, 1'b0, 1'b0, 32'h0000_0100, 4'b0000, 32'h0,        32'h0000_0022, 1'b0};
    vecs[6]  = '{1'b1, 3'b001, 32'h0000_0202, 32'h1234_ABCD, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'h0000_0200, 4'b1100, 32'hABCD_ABCD, 32'h0,        1'b0};
    vecs[7]  = '{1'b1, 3'b000, 32'h0000_0301, 32'h0000_00A5, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'h0000_0300, 4'b0010, 32'hA5A5_A5A5, 32'h0,        1'b0};
    vecs[8]  = '{1'b1, 3'b010, 32'h0000_0400, 32'h1122_3344, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'h0000_0400, 4'b1111, 32'h1122_3344, 32'h0,        1'b0};
    vecs[9]  = '{1'b0, 3'b010, 32'h0000_0500, 32'h0,        32'h1234_5678, 1'b1, 1'b0, 32'h0000_0500, 4'b0000, 32'h0,        32'h0,        1'b1};
    vecs[10] = '{1'b0, 3'b010, 32'h0000_0101, 32'h0,        32'h0,        1'b0, 1'b1, 32'h0,        4'b0000, 32'h0,        32'h0,        1'b1};
    vecs[11] = '{1'b1, 3'b100, 32'h0000_0100, 32'h55,       32'h0,        1'b0, 1'b1, 32'h0,        4'b0000, 32'h0,        32'h0,        1'b1};
    vecs[12] = '{1'b0, 3'b001, 32'h0000_0103, 32'h0,        32'h0,        1'b0, 1'b1, 32'h0,        4'b0000, 32'h0,        32'h0,        1'b1};
    vecs[13] = '{1'b0, 3'b011, 32'h0000_0100, 32'h0,        32'h0,        1'b0, 1'b1, 32'h0,        4'b0000, 32'h0,        32'h0,        1'b1};
    vecs[14] = '{1'b1, 3'b001, 32'h0000_0201, 32'h0,        32'h0,        1'b0, 1'b1, 32'h0,        4'b0000, 32'h0,        32'h0,        1'b1};

    rst_n = 1'b0;
    req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b000;
    req_addr = 32'h0; req_wdata = 32'h0;
    mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0; mem_err = 1'b0;
    #2;
    check("rst_req_ready", {31'd0, req_ready}, 32'd1);
    check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    check("rst_mem_valid", {31'd0, mem_valid}, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_resp_rdata", resp_rdata, 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < NV; i++) run_vec(i);

    // Stalled store: bus fields must hold while mem_ready is low; req_* and
    // spurious mem_rvalid in REQ must be ignored; then a bus error.
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010;
    req_addr = 32'h0000_0600; req_wdata = 32'hCAFE_F00D;
    tick();
    req_addr = 32'h0000_0704; req_wdata = 32'h0; req_funct3 = 3'b000; req_we = 1'b0;
    mem_rvalid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      check("stall_mem_valid", {31'd0, mem_valid}, 32'd1);
      check("stall_mem_addr", mem_addr, 32'h0000_0600);
      check("stall_mem_wstrb", {28'd0, mem_wstrb}, 32'hF);
      check("stall_mem_wdata", mem_wdata, 32'hCAFE_F00D);
      check("stall_mem_we", {31'd0, mem_we}, 32'd1);
      check("stall_req_ready", {31'd0, req_ready}, 32'd0);
      check("stall_resp_valid", {31'd0, resp_valid}, 32'd0);
      if (c < 4) tick();
    end
    req_valid = 1'b0;
    mem_rvalid = 1'b0;
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    check("stall_mem_valid_drop", {31'd0, mem_valid}, 32'd0);
    tick();
    check("wait_no_resp", {31'd0, resp_valid}, 32'd0);
    mem_rvalid = 1'b1; mem_err = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    tick();
    mem_rvalid = 1'b0; mem_err = 1'b0;
    check("buserr_resp_valid", {31'd0, resp_valid}, 32'd1);
    check("buserr_resp_err", {31'd0, resp_err}, 32'd1);
    check("buserr_resp_rdata", resp_rdata, 32'd0);
    tick();
    check("buserr_err_held", {31'd0, resp_err}, 32'd1);
    check("buserr_req_ready", {31'd0, req_ready}, 32'd1);
    $display("txn stall store addr=00000600 -> err=%0d (failures so far %0d)", resp_err, n_fail);

    // Reset while in WAIT abandons the access; a later stray mem_rvalid is ignored.
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010;
    req_addr = 32'h0000_0100;
    tick();
    req_valid = 1'b0;
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    check("prerst_req_ready", {31'd0, req_ready}, 32'd0);
    rst_n = 1'b0;
    #1;
    check("rst_wait_req_ready", {31'd0, req_ready}, 32'd1);
    check("rst_wait_mem_valid", {31'd0, mem_valid}, 32'd0);
    check("rst_wait_resp_valid", {31'd0, resp_valid}, 32'd0);
    check("rst_wait_mem_addr", mem_addr, 32'd0);
    tick();
    rst_n = 1'b1;
    mem_rvalid = 1'b1; mem_rdata = 32'h1111_1111;
    for (int c = 0; c < 3; c++) begin
      tick();
      check("stray_rvalid_resp", {31'd0, resp_valid}, 32'd0);
      check("stray_rvalid_ready", {31'd0, req_ready}, 32'd1);
    end
    mem_rvalid = 1'b0;
    $display("txn reset-in-wait -> resp_valid=%0d req_ready=%0d (failures so far %0d)",
             resp_valid, req_ready, n_fail);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
